seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 185 ++++++++++++++++++
 tb/tb_seq_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring radix-2 divider, signed (DIV) or unsigned (DIVU).
// One quotient bit per clock. A divide by zero finishes one cycle after
// accept. Results and the div-by-zero flag hold until the next completion.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; results held
// S_CALC | one shift/trial-subtract step per cycle, cnt_q steps remaining
// S_FIX  | apply result signs (or divide-by-zero values), strobe done
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;     // partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             zero_q, zero_d;   // operation in flight is a divide by zero
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH:0]   shifted, trial;

   assign dvd_neg = is_signed & dividend[WIDTH-1];
   assign dvs_neg = is_signed & divisor[WIDTH-1];
   // The most-negative value maps onto itself, which is its correct unsigned magnitude.
   assign dvd_mag = dvd_neg ? -dividend : dividend;
   assign dvs_mag = dvs_neg ? -divisor : divisor;

   // Trial subtract is WIDTH+1 bits wide so the shifted-out MSB is never lost.
   assign shifted = {acc_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      zero_d      = zero_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start && !busy_q && !flush) begin
               busy_d = 1'b1;
               acc_d  = '0;
               if (divisor == '0) begin
                  zero_d  = 1'b1;
                  quo_d   = dividend;
                  cnt_d   = '0;
                  state_d = S_FIX;
               end else begin
                  zero_d  = 1'b0;
                  quo_d   = dvd_mag;
                  dvs_d   = dvs_mag;
                  qneg_d  = dvd_neg ^ dvs_neg;
                  rneg_d  = dvd_neg;
                  cnt_d   = CW'(WIDTH);
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            if (flush) begin
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               if (!trial[WIDTH]) begin
                  acc_d = trial[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = shifted[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (zero_q) begin
                  quotient_d  = '1;
                  remainder_d = quo_q;
                  dbz_d       = 1'b1;
               end else begin
                  quotient_d  = qneg_q ? -quo_q : quo_q;
                  remainder_d = rneg_q ? -acc_q : acc_q;
                  dbz_d       = 1'b0;
               end
            end
         end

         default: begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         zero_q      <= zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH = 32.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int total = 0;
   int bad   = 0;
   int lat;
   int c;
   int ndone;

   seq_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one operation, then wait (bounded) for done; lat = edges from accept to done.
   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat_o);
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat_o = 0;
      while (!done && lat_o < 100) begin
         @(posedge clk); #1;
         lat_o++;
      end
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
      dividend = '0; divisor = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quo",  quotient, 32'd0);
      chk("rst_rem",  remainder, 32'd0);
      chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 100 / 7 unsigned
      run_op(1'b0, 32'd100, 32'd7, lat);
      chk("u_lat",  lat, 32'd33);
      chk("u_quo",  quotient, 32'd14);
      chk("u_rem",  remainder, 32'd2);
      chk("u_dbz",  {31'd0, div_by_zero}, 32'd0);
      chk("u_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("u_quo_hold", quotient, 32'd14);

      // -100 / 7 signed
      run_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat);
      chk("s_lat", lat, 32'd33);
      chk("s_quo", quotient, 32'hFFFF_FFF2);
      chk("s_rem", remainder, 32'hFFFF_FFFE);

      // divide by zero
      run_op(1'b0, 32'h1234_5678, 32'd0, lat);
      chk("z_lat",  lat, 32'd1);
      chk("z_quo",  quotient, 32'hFFFF_FFFF);
      chk("z_rem",  remainder, 32'h1234_5678);
      chk("z_dbz",  {31'd0, div_by_zero}, 32'd1);
      chk("z_busy", {31'd0, busy}, 32'd0);

      // signed overflow, also clears div_by_zero
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      chk("o_lat", lat, 32'd33);
      chk("o_quo", quotient, 32'h8000_0000);
      chk("o_rem", remainder, 32'd0);
      chk("o_dbz", {31'd0, div_by_zero}, 32'd0);

      // start while busy is ignored
      is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      c = 0;
      while (!done && c < 100) begin
         start = (c == 5);
         if (c == 5) begin
            dividend = 32'd7;
            divisor  = 32'd0;
         end
         @(posedge clk); #1;
         c++;
         if (c == 6) chk("busy_hold", {31'd0, busy}, 32'd1);
      end
      start = 1'b0;
      chk("ign_lat", c, 32'd33);
      chk("ign_quo", quotient, 32'd100);
      chk("ign_rem", remainder, 32'd0);
      chk("ign_dbz", {31'd0, div_by_zero}, 32'd0);

      // back-to-back: start presented in the done cycle
      run_op(1'b0, 32'd55, 32'd5, lat);
      chk("b2b_lat", lat, 32'd33);
      chk("b2b_quo", quotient, 32'd11);

      // flush at cycle 10, with a competing start in the same cycle
      is_signed = 1'b0; dividend = 32'd200; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd0;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      chk("fl_busy", {31'd0, busy}, 32'd0);
      chk("fl_done", {31'd0, done}, 32'd0);
      count_done(40, ndone);
      chk("fl_no_done", ndone, 32'd0);
      chk("fl_quo_held", quotient, 32'd11);
      chk("fl_rem_held", remainder, 32'd0);

      // asynchronous reset mid-operation
      is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) begin @(posedge clk); #1; end
      #3 rst = 1'b1;
      #1;
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_done", {31'd0, done}, 32'd0);
      chk("ar_quo",  quotient, 32'd0);
      chk("ar_rem",  remainder, 32'd0);
      chk("ar_dbz",  {31'd0, div_by_zero}, 32'd0);
      #2 rst = 1'b0;
      count_done(40, ndone);
      chk("ar_no_done", ndone, 32'd0);

      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat);
      chk("pr_lat", lat, 32'd33);
      chk("pr_quo", quotient, 32'hFFFF_FFFF);
      chk("pr_rem", remainder, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
